// File: rtl/handshake_fifo_if.sv
// Req/ack handshake bundle around handshake_fifo: upstream (req_in/ack_in/din)
// and downstream (req_out/ack_out/dout). The fifo uses "slave", its neighbours "master".
interface handshake_fifo_if #(
   parameter int data_width = 32
);
   logic                  req_in;
   logic                  ack_in;
   logic [data_width-1:0] din;
   logic                  req_out;
   logic                  ack_out;
   logic [data_width-1:0] dout;

   modport slave (
      output req_in, ack_out, dout,
      input  ack_in, din, req_out
   );

   modport master (
      input  req_in, ack_out, dout,
      output ack_in, din, req_out
   );
endinterface

// File: rtl/handshake_fifo.sv
// Elastic req/ack buffer: requester upstream, responder downstream, circular RAM.
// Define HANDSHAKE_FIFO_STATS_EN to build max_level/wr_total/rd_total and the unsolicited-ack message.
module handshake_fifo #(
   parameter int data_width = 32,
   parameter int depth      = 4,
   parameter int fifo_id    = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   handshake_fifo_if.slave        bus,
   output logic [$clog2(depth):0] level,
   output logic [$clog2(depth):0] max_level,
   output logic [31:0]            wr_total,
   output logic [31:0]            rd_total
);
   localparam int unsigned AW = $clog2(depth);

   typedef logic [AW-1:0] ptr_t;
   typedef logic [AW:0]   lvl_t;

   localparam lvl_t DEPTH_L = lvl_t'(depth);

   logic [data_width-1:0] mem_q [depth];
   logic [data_width-1:0] mem_d [depth];
   ptr_t                  wr_ptr_q, wr_ptr_d;
   ptr_t                  rd_ptr_q, rd_ptr_d;
   lvl_t                  level_q, level_d;
   logic                  req_in_q, req_in_d;
   logic                  ack_out_q, ack_out_d;
   logic [data_width-1:0] dout_q, dout_d;
   logic                  wr, rd;

   always_comb begin
      // an ack is only honoured while our own request is up
      wr        = bus.ack_in & req_in_q;
      // reads see the registered level, so a fresh word waits one edge
      rd        = bus.req_out & ~ack_out_q & (level_q != '0);
      wr_ptr_d  = wr ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
      rd_ptr_d  = rd ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
      level_d   = level_q + lvl_t'(wr) - lvl_t'(rd);
      req_in_d  = (level_d < DEPTH_L);
      ack_out_d = rd;
      dout_d    = rd ? mem_q[rd_ptr_q] : dout_q;
      mem_d     = mem_q;
      if (wr) begin
         mem_d[wr_ptr_q] = bus.din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         req_in_q  <= 1'b0;
         ack_out_q <= 1'b0;
         dout_q    <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         req_in_q  <= req_in_d;
         ack_out_q <= ack_out_d;
         dout_q    <= dout_d;
      end
   end

   // contents need no reset: pointers and level already discard them
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign bus.req_in  = req_in_q;
   assign bus.ack_out = ack_out_q;
   assign bus.dout    = dout_q;
   assign level       = level_q;

`ifdef HANDSHAKE_FIFO_STATS_EN
   lvl_t        max_level_q, max_level_d;
   logic [31:0] wr_total_q, wr_total_d;
   logic [31:0] rd_total_q, rd_total_d;

   always_comb begin
      max_level_d = (level_d > max_level_q) ? level_d : max_level_q;
      wr_total_d  = wr_total_q + 32'(wr);
      rd_total_d  = rd_total_q + 32'(rd);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         max_level_q <= '0;
         wr_total_q  <= '0;
         rd_total_q  <= '0;
      end else begin
         max_level_q <= max_level_d;
         wr_total_q  <= wr_total_d;
         rd_total_q  <= rd_total_d;
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!rst && bus.ack_in && !req_in_q) begin
         $display("fifo_%0d: unsolicited ack", fifo_id);
      end
   end
`endif

   assign max_level = max_level_q;
   assign wr_total  = wr_total_q;
   assign rd_total  = rd_total_q;
`else
   assign max_level = '0;
   assign wr_total  = '0;
   assign rd_total  = '0;
`endif
endmodule

// File: tb/tb_handshake_fifo.sv
// Randomized scoreboard bench for handshake_fifo: producer/consumer drivers,
// a queue-based occupancy model, and a monitor that checks every cycle.
module tb_handshake_fifo;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  level, max_level;
   logic [31:0] wr_total, rd_total;

   handshake_fifo_if #(.data_width(DW)) bus ();

   handshake_fifo #(.data_width(DW), .depth(DEPTH), .fifo_id(0)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .level     (level),
      .max_level (max_level),
      .wr_total  (wr_total),
      .rd_total  (rd_total)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- drivers ----------------
   bit          prod_en = 0, cons_en = 0, force_ack = 0;
   int unsigned pfail = 0, cfail = 0;
   logic [31:0] prod_cnt = '0;

   initial begin
      bus.ack_in  = 1'b0;
      bus.din     = '0;
      bus.req_out = 1'b0;
   end

   always begin
      @(posedge clk);
      #1;
      if (force_ack) begin
         bus.ack_in = 1'b1;
         bus.din    = 32'hDEAD_BEEF;
         force_ack  = 0;
      end else if (bus.ack_in) begin
         bus.ack_in = 1'b0;
      end else if (prod_en && bus.req_in && ($urandom_range(99) >= pfail)) begin
         bus.ack_in = 1'b1;
         bus.din    = prod_cnt;
         prod_cnt   = prod_cnt + 1;
      end
   end

   always begin
      @(posedge clk);
      #1;
      bus.req_out = cons_en && ($urandom_range(99) >= cfail);
   end

   // ---------------- reference model ----------------
   logic [31:0] exp_q[$];
   int          m_level = 0, m_max = 0;
   bit          m_req = 0, m_ack = 0;
   logic [31:0] m_dout = '0;
   logic [31:0] m_wr = '0, m_rd = '0;

   always @(posedge clk) begin
      bit w, r;
      if (rst) begin
         exp_q.delete();
         m_level = 0; m_max = 0; m_req = 0; m_ack = 0;
         m_dout = '0; m_wr = '0; m_rd = '0;
      end else begin
         r = bus.req_out && !m_ack && (m_level > 0);
         w = bus.ack_in && m_req;
         if (r) m_dout = exp_q[0];
         if (w) exp_q.push_back(bus.din);
         m_level = m_level + int'(w) - int'(r);
         m_req   = (m_level < DEPTH);
         m_ack   = r;
         if (m_level > m_max) m_max = m_level;
         m_wr = m_wr + 32'(w);
         m_rd = m_rd + 32'(r);
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [31:0] e;
      check("req_in", bus.req_in, m_req);
      check("ack_out", bus.ack_out, m_ack);
      check("level", level, m_level);
      if (bus.ack_out) begin
         if (exp_q.size() == 0) begin
            check("unexpected_ack", bus.ack_out, 0);
         end else begin
            e = exp_q.pop_front();
            check("dout", bus.dout, e);
         end
      end else begin
         check("dout_hold", bus.dout, m_dout);
      end
`ifdef HANDSHAKE_FIFO_STATS_EN
      check("max_level", max_level, m_max);
      check("wr_total", wr_total, m_wr);
      check("rd_total", rd_total, m_rd);
`else
      check("max_level_tied", max_level, 0);
      check("wr_total_tied", wr_total, 0);
      check("rd_total_tied", rd_total, 0);
`endif
   end

   // ---------------- sequence ----------------
   initial begin
      int          acks, pt_max, dr_min;
      logic [31:0] start, first_exp;
      bit          seen;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // pass-through at full rate
      pfail = 0; cfail = 0; prod_en = 1; cons_en = 1;
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = bus.ack_out;
      end
      check("pt_first_ack_seen", seen, 1);
      acks = 0; pt_max = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.ack_out) acks++;
         if (int'(level) > pt_max) pt_max = int'(level);
      end
      check("pt_ack_every_2", acks, 20);
      check("pt_level_le_1", (pt_max <= 1), 1);

      // fill with consumer stalled
      cons_en = 0;
      repeat (20) @(negedge clk);
      check("fill_level", level, 4);
      check("fill_req_in", bus.req_in, 0);
`ifdef HANDSHAKE_FIFO_STATS_EN
      check("fill_max_level", max_level, 4);
`endif

      // drain 20 words while the producer keeps up
      cons_en = 1;
      start = m_rd; dr_min = 4;
      for (int i = 0; i < 200 && (m_rd - start) < 20; i++) begin
         @(negedge clk);
         if (int'(level) < dr_min) dr_min = int'(level);
      end
      check("drain_20_words", ((m_rd - start) >= 20), 1);
      check("drain_level_ge_3", (dr_min >= 3), 1);

      // random stalls on both sides
      pfail = 30; cfail = 30;
      start = m_rd;
      for (int i = 0; i < 60000 && (m_rd - start) < 5000; i++) @(negedge clk);
      check("stall_5000_words", ((m_rd - start) >= 5000), 1);
`ifdef HANDSHAKE_FIFO_STATS_EN
      check("stall_totals_vs_level", wr_total - rd_total, 32'(level));
`endif

      // mid-operation reset at level 3, with an ack landing on the reset edge
      pfail = 0; cons_en = 0;
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         seen = (m_level == 3) && !bus.ack_in;
      end
      check("reset_reached_level3", seen, 1);
      prod_en = 0; force_ack = 1;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      first_exp = prod_cnt;
      @(negedge clk);
      check("rst_level", level, 0);
      check("rst_ack_out", bus.ack_out, 0);
      check("rst_dout", bus.dout, 0);
      check("rst_req_in", bus.req_in, 0);
      prod_en = 1; cfail = 0; cons_en = 1;
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = bus.ack_out;
      end
      check("post_rst_ack_seen", seen, 1);
      if (seen) check("post_rst_first_word", bus.dout, first_exp);

      // unsolicited ack while full
      cons_en = 0;
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         seen = (m_level == DEPTH) && !bus.ack_in;
      end
      check("unsol_full", seen, 1);
      prod_en = 0; force_ack = 1;
      repeat (3) @(negedge clk);
      check("unsol_level", level, 4);
      check("unsol_req_in", bus.req_in, 0);
      prod_en = 1; cons_en = 1;
      start = m_rd;
      for (int i = 0; i < 200 && (m_rd - start) < 12; i++) @(negedge clk);
      check("unsol_drain", ((m_rd - start) >= 12), 1);

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
